// File: rtl/pmodcharlie_pkg.sv
// pmodcharlie_pkg: shared charlieplex geometry, glyph table and cathode mapping.
package pmodcharlie_pkg;
  localparam int NUM_PINS = 8;
  localparam int NUM_DIGITS = 8;
  localparam int NUM_SEGS = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {CLS_DEAD, CLS_PHASE, CLS_MULTI} cls_t;
  function automatic logic [2:0] cathode(input logic [2:0] d, input logic [2:0] s);
    return d + s + 3'd1;
  endfunction
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: map a 7-segment pattern back to its hex nibble, flagging non-glyphs.
module seg7_to_hex
  import pmodcharlie_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] hex,
  output logic       err
);
  always_comb begin
    hex = '0;
    err = 1'b1;
    for (int i = 0; i < 16; i++)
      if (pat == GLYPH[i]) begin
        hex = 4'(i);
        err = 1'b0;
      end
  end
endmodule

// File: rtl/pmodcharlie_rx.sv
// pmodcharlie_rx: recover digit segments from charlieplexed pmod pins and decode full frames.
module pmodcharlie_rx
  import pmodcharlie_pkg::*;
#(
  parameter int MIN_STABLE = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pin_drv,
  input  logic [7:0]  pin_val,
  output logic [31:0] data,
  output logic [55:0] segs,
  output logic [7:0]  digit_err,
  output logic        frame_valid,
  output logic        proto_err,
  output logic        active
);
  localparam int SW = $clog2(MIN_STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [7:0] s_drv, s_val, p_drv, p_val, hi, lo, seen, derr;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [6:0] seg_reg [NUM_DIGITS];
  logic [3:0] nib [NUM_DIGITS];
  logic [6:0] pat;
  logic [2:0] ph;
  logic commit, take, timeout;
  cls_t cls;
  always_comb begin
    hi = s_drv & s_val;
    lo = s_drv & ~s_val;
    commit = scnt == SW'(MIN_STABLE - 1);
    cls = hi == '0 ? CLS_DEAD : (hi & (hi - 8'd1)) == '0 ? CLS_PHASE : CLS_MULTI;
    ph = '0;
    for (int i = 0; i < NUM_PINS; i++)
      if (hi[i]) ph = 3'(i);
    pat = '0;
    for (int s = 0; s < NUM_SEGS; s++)
      pat[s] = lo[cathode(ph, 3'(s))];
    take = commit && cls == CLS_PHASE;
    timeout = tcnt == TW'(TIMEOUT);
  end
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    seg7_to_hex u_dec (.pat(seg_reg[d]), .hex(nib[d]), .err(derr[d]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_drv <= '0;
      s_val <= '0;
      p_drv <= '0;
      p_val <= '0;
      scnt <= '0;
      tcnt <= '0;
      seen <= '0;
      data <= '0;
      segs <= '0;
      digit_err <= '0;
      frame_valid <= 1'b0;
      proto_err <= 1'b0;
      active <= 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) seg_reg[d] <= '0;
    end else begin
      s_drv <= pin_drv;
      s_val <= pin_val;
      p_drv <= s_drv;
      p_val <= s_val;
      scnt <= {s_drv, s_val} != {p_drv, p_val} ? '0 : scnt == SW'(MIN_STABLE) ? scnt : scnt + SW'(1);
      proto_err <= commit && cls == CLS_MULTI;
      frame_valid <= seen == '1;
      if (seen == '1) begin
        digit_err <= derr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
          segs[7*d +: 7] <= seg_reg[d];
          data[4*d +: 4] <= nib[d];
        end
      end
      // dead-time commits neither refresh the timeout nor touch the frame
      tcnt <= take ? '0 : timeout ? tcnt : tcnt + TW'(1);
      if (seen == '1 || (timeout && !take)) seen <= '0;
      if (take) begin
        seg_reg[ph] <= pat;
        seen[ph] <= 1'b1;
        active <= 1'b1;
      end else if (timeout) begin
        active <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pmodcharlie_rx.sv
// tb_pmodcharlie_rx: directed scoreboard bench for the charlieplex receiver.
module tb_pmodcharlie_rx;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] pin_drv, pin_val;
  logic [31:0] data;
  logic [55:0] segs;
  logic [7:0] digit_err;
  logic frame_valid, proto_err, active;
  typedef struct {
    logic [31:0] d;
    logic [55:0] s;
    logic [7:0]  e;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, fv_cnt = 0, pe_cnt = 0;
  localparam logic [6:0] G [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  pmodcharlie_rx dut (
    .clk(clk), .rst(rst), .pin_drv(pin_drv), .pin_val(pin_val), .data(data),
    .segs(segs), .digit_err(digit_err), .frame_valid(frame_valid),
    .proto_err(proto_err), .active(active)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [55:0] enc(input logic [31:0] w);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) r[7*d +: 7] = G[w[4*d +: 4]];
    return r;
  endfunction
  always @(negedge clk) begin
    if (proto_err) pe_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      if (q.size() == 0) check("unexpected_frame", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("frame_data", data, e.d);
        check("frame_segs", segs, e.s);
        check("frame_err", digit_err, e.e);
      end
    end
  end
  task automatic phase(input int p, input logic [6:0] pat, input int hold);
    logic [7:0] lo;
    lo = '0;
    for (int s = 0; s < 7; s++) if (pat[s]) lo[(p + s + 1) % 8] = 1'b1;
    @(negedge clk);
    pin_drv = lo | (8'd1 << p);
    pin_val = 8'd1 << p;
    repeat (hold) @(negedge clk);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    pin_drv = '0;
    pin_val = '0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [55:0] pats, input logic [31:0] d, input logic [7:0] e);
    q.push_back('{d: d, s: pats, e: e});
    for (int p = 0; p < 8; p++) phase(p, pats[7*p +: 7], 16);
    idle(10);
  endtask
  initial begin
    logic [55:0] pats;
    int base;
    rst = 1'b1;
    pin_drv = '0;
    pin_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_segs", segs, 0);
    check("rst_err", digit_err, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_pe", proto_err, 0);
    check("rst_active", active, 0);
    send_frame(enc(32'hDEADBEEF), 32'hDEADBEEF, 8'h00);
    check("deadbeef_done", q.size(), 0);
    check("deadbeef_count", fv_cnt, 1);
    check("deadbeef_digit0", segs[6:0], 7'h71);
    check("active_after_frame", active, 1);
    pats = enc(32'h01234567);
    base = fv_cnt;
    for (int p = 0; p < 3; p++) phase(p, pats[7*p +: 7], 16);
    phase(3, pats[21 +: 7], 1);
    for (int p = 4; p < 8; p++) phase(p, pats[7*p +: 7], 16);
    idle(20);
    check("short_phase_no_frame", fv_cnt, base);
    q.push_back('{d: 32'h01234567, s: pats, e: 8'h00});
    phase(3, pats[21 +: 7], 16);
    idle(10);
    check("short_phase_done", q.size(), 0);
    check("short_phase_count", fv_cnt, base + 1);
    base = pe_cnt;
    @(negedge clk);
    pin_drv = 8'h11;
    pin_val = 8'h11;
    repeat (16) @(negedge clk);
    idle(10);
    check("proto_pulse_once", pe_cnt, base + 1);
    check("proto_data_held", data, 32'h01234567);
    check("proto_no_frame", fv_cnt, 2);
    pats = enc(32'h89ABCDEF);
    for (int p = 0; p < 6; p++) phase(p, pats[7*p +: 7], 16);
    check("active_before_timeout", active, 1);
    idle(4200);
    check("active_after_timeout", active, 0);
    base = fv_cnt;
    for (int p = 6; p < 8; p++) phase(p, pats[7*p +: 7], 16);
    idle(20);
    check("timeout_no_frame", fv_cnt, base);
    for (int p = 0; p < 5; p++) phase(p, pats[7*p +: 7], 16);
    idle(4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_active", active, 0);
    for (int p = 5; p < 8; p++) phase(p, pats[7*p +: 7], 16);
    idle(20);
    check("midrst_no_frame", fv_cnt, base);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pats = enc(32'hFEDCB1A9);
    q.push_back('{d: 32'hFEDCB1A9, s: pats, e: 8'h00});
    phase(7, pats[49 +: 7], 16);
    phase(2, G[8], 16);
    phase(2, pats[14 +: 7], 16);
    phase(0, pats[0 +: 7], 16);
    phase(1, pats[7 +: 7], 16);
    for (int p = 3; p < 7; p++) phase(p, pats[7*p +: 7], 16);
    idle(10);
    check("reorder_done", q.size(), 0);
    check("reorder_count", fv_cnt, base + 1);
    check("reorder_digit2", data[11:8], 4'h1);
    pats = enc(32'h12345678);
    pats[35 +: 7] = 7'h01;
    send_frame(pats, 32'h12045678, 8'h20);
    check("bad_glyph_done", q.size(), 0);
    check("bad_glyph_err", digit_err, 8'h20);
    check("final_count", fv_cnt, base + 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmodcharlie_rx.md
Name: pmodcharlie_rx

Overview:
- Receive-side counterpart of the pmodcharlie charlieplexed 8-digit 7-segment driver.
- Observes the 8 tristate pmod pins (drive-enable plus value per pin), recovers each digit's segment pattern, and decodes a complete scan frame back into a 32-bit hex word.
- Used in-fabric as a loopback checker behind the driver and as a bench monitor.

Parameters:
- MIN_STABLE, 4, consecutive identical samples required before a phase is committed (glitch filter).
- TIMEOUT, 4096, cycles without a commit before the partial frame is discarded and active drops.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous to clk, active-high
- pin_drv  in  8  1 = pin actively driven, 0 = high-Z
- pin_val  in  8  driven level; ignored where pin_drv=0
- data  out  32  decoded frame; digit d in bits [4d+3:4d]
- segs  out  56  raw segments; digit d in bits [7d+6:7d], bit0=a .. bit6=g
- digit_err  out  8  digit d pattern is not a hex glyph
- frame_valid  out  1  one-cycle pulse when data/segs/digit_err update
- proto_err  out  1  one-cycle pulse per malformed committed phase
- active  out  1  frame activity seen within TIMEOUT cycles

Behaviour:
- Protocol (decided):
  - LED (digit d 0..7, segment s 0..6) has anode pin d and cathode pin (d+s+1) mod 8.
  - Phase p: pin p driven high. Each pin (p+s+1) mod 8 driven low lights segment s. Undriven pins are off.
- Reset: data=0, segs=0, digit_err=0, frame_valid=0, proto_err=0, active=0, seen mask=0, counters=0. Reset mid-frame discards all partial state; no frame_valid follows.
- Sampling:
  - pin_drv/pin_val registered once → sample.
  - Stability counter increments while sample equals the previous sample and resets to 0 on any change.
  - Commit fires exactly once, on the cycle the counter reaches MIN_STABLE-1 (the sample has been constant MIN_STABLE cycles). It does not re-fire until the sample changes.
- Commit classification; hi = drv & val, lo = drv & ~val:
  - hi == 0: dead time. Ignored: no state change, no error, timeout not reset.
  - hi onehot at p: segment bit s of digit p = lo[(p+s+1) mod 8]. Write seg_reg[p], set seen[p], reset timeout counter, active=1. A repeated p overwrites seg_reg[p].
  - hi has 2 or more bits set: proto_err pulses on the next cycle. Nothing else changes.
- Frame completion:
  - When a commit makes seen == 8'hFF, on the next cycle: frame_valid=1, segs <= seg_reg, data and digit_err <= glyph-decoded seg_reg, and seen cleared.
  - Phase order is irrelevant.
  - Latency: a pin change yields a commit MIN_STABLE+1 cycles later; frame_valid follows the final commit by 1 cycle.
- Glyph table (g..a hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Any other pattern: nibble=0 and digit_err[d]=1.
- Timeout:
  - Counter saturates at TIMEOUT.
  - On reaching TIMEOUT: seen cleared, active=0, data/segs held.
  - A commit on the same cycle as timeout wins: counter reset, commit applied.
- Widths: stability counter $clog2(MIN_STABLE+1); timeout counter $clog2(TIMEOUT+1).
- Outputs are registered; no combinational path from pins to any output.

Decomposition:
- pmodcharlie_pkg:
  - NUM_PINS=8, NUM_DIGITS=8, NUM_SEGS=7.
  - Segment index constants a..g.
  - Glyph table constants.
  - Cathode-pin function (d+s+1) mod 8, shared with the transmit driver.
- Sub-module seg7_to_hex: combinational 7-bit pattern → {err, nibble}, instantiated 8 times.

Test Plan:
- Full frame for 32'hDEADBEEF, phases 0..7, each held 16 cycles. Phase 0 example: pin0 high; pins 1,5,6,7 low; pins 2,3,4 Z → one frame_valid, data=32'hDEADBEEF, digit_err=0, segs digit0=7'h71.
- Phase 3 held 2 cycles (< MIN_STABLE) between valid phases → no commit, seen[3] stays 0, no frame_valid until phase 3 is held ≥4 cycles.
- Stable sample with pins 0 and 4 both driven high → proto_err pulses once, seen unchanged, data unchanged.
- Phases 0..5 committed, then all pins Z for 4096 cycles → active falls, seen cleared. Phases 6,7 alone then produce no frame_valid.
- Phases in order 7,2,2,0,1,3,4,5,6, with the second phase-2 pattern 7'h06 → frame_valid once; digit 2 nibble=1 (last write wins).
- rst asserted after 5 phases, then phases 5..7 → no frame_valid. Digit pattern 7'h01 in a full frame → digit_err bit set and that nibble=0.
